mem_responder: RTL and testbench

Memory-side responder for the CPU bus Read/Write strobes that the control sequencer drives alongside MARin/MDRin. It latches the MAR address, inserts a programmable number of wait states, then returns read data on Mdatain or commits MDR write data. It signals completion with a one-cycle ready pulse. It replaces the hand-driven Mdatain stimulus and sits between the MAR/MDR registers and a single-port word RAM.

---
 rtl/cpu_mem_pkg.sv | 21 ++
 rtl/mem_array.sv | 37 +++
 rtl/mem_responder.sv | 114 +++++++++++
 tb/tb_mem_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types and defaults for the CPU memory responder
package cpu_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 9;

  // Responder sequencing states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACCESS  = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Latched operation of the accepted request
  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous word RAM with registered, hold-on-idle read data
module mem_array
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write; contents survive reset, the caller gates we during reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register only loads on a read access so it holds the last read word
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - Read/Write strobe responder with wait states in front of a word RAM
module mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [ADDR_W-1:0] mar_addr,
  input  logic              Read,
  input  logic              Write,
  input  logic [DATA_W-1:0] mdr_wdata,
  output logic [DATA_W-1:0] Mdatain,
  output logic              mem_ready,
  output logic              mem_busy,
  output logic              mem_err
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  op_t               op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        wait_cnt;
  logic              ready_q;
  logic              busy_q;
  logic              err_q;

  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  // RAM is touched only in ACCESS; a coincident reset suppresses the write
  always_comb begin
    ram_we = 1'b0;
    ram_re = 1'b0;
    if (state == ACCESS && !clr) begin
      ram_we = (op_q == OP_WR);
      ram_re = (op_q == OP_RD);
    end
  end

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem_array (
    .clk   (clk),
    .clr   (clr),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (addr_q),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Request sequencing: accept, count wait states, one access, then wait for strobes to drop
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      op_q     <= OP_RD;
      addr_q   <= '0;
      wdata_q  <= '0;
      wait_cnt <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (Read && Write) begin
            err_q <= 1'b1;
            state <= RELEASE;
          end else if (Read || Write) begin
            addr_q   <= mar_addr;
            wdata_q  <= mdr_wdata;
            op_q     <= Write ? OP_WR : OP_RD;
            wait_cnt <= WAIT_INIT;
            busy_q   <= 1'b1;
            state    <= (WAIT_INIT == 4'd0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) begin
            state <= ACCESS;
          end
        end
        ACCESS: begin
          // Ready rises at the same edge the RAM read register loads
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= RELEASE;
        end
        RELEASE: begin
          if (!Read && !Write) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign Mdatain   = ram_rdata;
  assign mem_ready = ready_q;
  assign mem_busy  = busy_q;
  assign mem_err   = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder at WAIT_CYCLES 0, 1 and 3
module tb_mem_responder;

  logic        clk;
  logic        clr_s [3];
  logic        rd    [3];
  logic        wr    [3];
  logic [8:0]  addr  [3];
  logic [31:0] wd    [3];
  logic [31:0] mdat  [3];
  logic        rdy   [3];
  logic        busy  [3];
  logic        err   [3];

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WAIT_CYCLES=0, instance 1: 1, instance 2: 3
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .ADDR_W      (9),
      .DATA_W      (32),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 1 : 3))
    ) dut (
      .clk       (clk),
      .clr       (clr_s[g]),
      .mar_addr  (addr[g]),
      .Read      (rd[g]),
      .Write     (wr[g]),
      .mdr_wdata (wd[g]),
      .Mdatain   (mdat[g]),
      .mem_ready (rdy[g]),
      .mem_busy  (busy[g]),
      .mem_err   (err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request; inputs are scrambled after acceptance to prove they were latched
  task automatic access(input int i, input bit is_wr, input logic [8:0] a, input logic [31:0] d,
                        output int lat, output int bcnt, output logic [31:0] rdat);
    lat  = -1;
    bcnt = 0;
    rdat = '0;
    addr[i] = a;
    wd[i]   = d;
    rd[i]   = !is_wr;
    wr[i]   = is_wr;
    for (int k = 1; k <= 20 && lat < 0; k++) begin
      tick();
      if (k == 1) begin
        addr[i] = ~a;
        wd[i]   = ~d;
      end
      if (busy[i]) bcnt++;
      if (rdy[i]) begin
        lat  = k - 1;
        rdat = mdat[i];
      end
    end
    if (lat < 0) check("ready_timeout", 32'hFFFF_FFFF, 32'(i));
    rd[i] = 1'b0;
    wr[i] = 1'b0;
    tick();
  endtask

  int          lat;
  int          bc;
  int          pulses;
  int          errs;
  logic [31:0] rdat;

  initial begin
    for (int i = 0; i < 3; i++) begin
      clr_s[i] = 1'b1;
      rd[i]    = 1'b0;
      wr[i]    = 1'b0;
      addr[i]  = '0;
      wd[i]    = '0;
    end
    tick();
    tick();
    for (int i = 0; i < 3; i++) clr_s[i] = 1'b0;
    check("reset_mdatain", mdat[1], 32'h0);
    check("reset_ready", 32'(rdy[1]), 32'h0);
    check("reset_busy", 32'(busy[1]), 32'h0);
    check("reset_err", 32'(err[1]), 32'h0);
    tick();

    // Write then read with one wait state
    access(1, 1'b1, 9'h000, 32'h2891_8000, lat, bc, rdat);
    check("w1_write_latency", 32'(lat), 32'd2);
    check("w1_write_busy", 32'(bc), 32'd2);
    access(1, 1'b0, 9'h000, 32'h0, lat, bc, rdat);
    check("w1_read_latency", 32'(lat), 32'd2);
    check("w1_read_data", rdat, 32'h2891_8000);
    tick();
    tick();
    check("w1_mdatain_hold", mdat[1], 32'h2891_8000);
    access(1, 1'b1, 9'h005, 32'h1234_5678, lat, bc, rdat);
    check("w1_write_keeps_mdatain", mdat[1], 32'h2891_8000);

    // Latency sweep
    access(0, 1'b1, 9'h012, 32'h0000_0012, lat, bc, rdat);
    access(0, 1'b0, 9'h012, 32'h0, lat, bc, rdat);
    check("w0_read_latency", 32'(lat), 32'd1);
    check("w0_read_busy", 32'(bc), 32'd1);
    check("w0_read_data", rdat, 32'h0000_0012);
    access(2, 1'b1, 9'h012, 32'h0000_0012, lat, bc, rdat);
    access(2, 1'b0, 9'h012, 32'h0, lat, bc, rdat);
    check("w3_read_latency", 32'(lat), 32'd4);
    check("w3_read_busy", 32'(bc), 32'd4);
    check("w3_read_data", rdat, 32'h0000_0012);

    // Held strobe: one pulse per assertion
    access(1, 1'b1, 9'h014, 32'hA5A5_A5A5, lat, bc, rdat);
    addr[1] = 9'h014;
    rd[1]   = 1'b1;
    pulses  = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (rdy[1]) pulses++;
    end
    check("held_single_pulse", 32'(pulses), 32'd1);
    check("held_data", mdat[1], 32'hA5A5_A5A5);
    rd[1] = 1'b0;
    tick();
    rd[1]  = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (rdy[1]) pulses++;
    end
    check("held_second_pulse", 32'(pulses), 32'd1);
    rd[1] = 1'b0;
    tick();

    // Illegal request: both strobes
    access(1, 1'b1, 9'h018, 32'h0BAD_F00D, lat, bc, rdat);
    addr[1] = 9'h018;
    wd[1]   = 32'hDEAD_BEEF;
    rd[1]   = 1'b1;
    wr[1]   = 1'b1;
    pulses  = 0;
    errs    = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) check("illegal_err_first_cycle", 32'(err[1]), 32'd1);
      if (rdy[1]) pulses++;
      if (err[1]) errs++;
    end
    check("illegal_err_count", 32'(errs), 32'd1);
    check("illegal_no_ready", 32'(pulses), 32'd0);
    rd[1] = 1'b0;
    wr[1] = 1'b0;
    tick();
    access(1, 1'b0, 9'h018, 32'h0, lat, bc, rdat);
    check("illegal_ram_unchanged", rdat, 32'h0BAD_F00D);

    // Reset during WAIT aborts the write at the top address
    access(2, 1'b1, 9'h1FF, 32'h0000_0000, lat, bc, rdat);
    access(2, 1'b0, 9'h012, 32'h0, lat, bc, rdat);
    check("rst_pre_mdatain", mdat[2], 32'h0000_0012);
    addr[2] = 9'h1FF;
    wd[2]   = 32'hFFFF_FFFF;
    wr[2]   = 1'b1;
    tick();
    tick();
    check("rst_busy_in_wait", 32'(busy[2]), 32'd1);
    clr_s[2] = 1'b1;
    wr[2]    = 1'b0;
    tick();
    clr_s[2] = 1'b0;
    pulses   = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rdy[2]) pulses++;
    end
    check("rst_no_ready", 32'(pulses), 32'd0);
    check("rst_mdatain_zero", mdat[2], 32'h0);
    check("rst_busy_low", 32'(busy[2]), 32'd0);
    access(2, 1'b0, 9'h1FF, 32'h0, lat, bc, rdat);
    check("rst_top_addr_prior", rdat, 32'h0000_0000);
    check("rst_top_addr_latency", 32'(lat), 32'd4);

    // Reset coincident with ACCESS suppresses the write and clears Mdatain
    check("acc_rst_pre_mdatain", mdat[0], 32'h0000_0012);
    addr[0] = 9'h012;
    wd[0]   = 32'h7777_7777;
    wr[0]   = 1'b1;
    tick();
    clr_s[0] = 1'b1;
    tick();
    check("acc_rst_mdatain_zero", mdat[0], 32'h0);
    check("acc_rst_no_ready", 32'(rdy[0]), 32'd0);
    clr_s[0] = 1'b0;
    wr[0]    = 1'b0;
    tick();
    access(0, 1'b0, 9'h012, 32'h0, lat, bc, rdat);
    check("acc_rst_write_suppressed", rdat, 32'h0000_0012);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
